// File: rtl/bitwise_pipe_pkg.sv
// Shared encodings for the bitwise pipeline: operation codes, buffer occupancy states
// and the width/limit of the optional deliver counter.
package bitwise_pipe_pkg;

    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_e;

    localparam int unsigned COUNT_WIDTH = 16;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    // Upstream may only be offered a slot while the skid register is free.
    function automatic logic can_accept(state_e s);
        return s != ST_TWO;
    endfunction

endpackage

// File: rtl/bitwise_op.sv
// Combinational bitwise function unit: NOT a, AND, OR, XOR over all WIDTH bits.
module bitwise_op #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    import bitwise_pipe_pkg::*;

    always_comb begin
        y = '0;
        unique case (op_e'(op))
            OP_NOT: y = ~a;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
        endcase
    end

endmodule

// File: rtl/bitwise_pipe.sv
// Bitwise operation pipeline with a two-entry (output + skid) valid/ready buffer.
// Optional feature: define BITWISE_PIPE_COUNT_EN to add a saturating deliver counter port.
module bitwise_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef BITWISE_PIPE_COUNT_EN
    ,
    output logic [15:0]      count
`endif
);
    import bitwise_pipe_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             deliver;

    bitwise_op #(
        .WIDTH (WIDTH)
    ) u_op (
        .op (op),
        .a  (a),
        .b  (b),
        .y  (result)
    );

    assign accept    = in_valid & in_ready_q;
    assign deliver   = out_valid & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_d   = result;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    out_d = result;
                end else if (accept) begin
                    // Output is stalled, so park the new result behind it.
                    skid_d  = result;
                    state_d = ST_TWO;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (deliver) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Reset overrides every handshake, discarding both buffered entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= can_accept(state_d);
        end
    end

`ifdef BITWISE_PIPE_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (deliver && (count_q != COUNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
`endif

endmodule
